// File: rtl/gps_ack_multi.sv
// gps_ack_multi: GPS L1 C/A acquisition engine searching N_CH PRNs in parallel per group
// over 1023 code phases x N_DOPP Doppler bins. Define GPS_ACK_IQ_EN for complex (I/Q) input.
module gps_ack_multi #(
    parameter int SAMPLE_BITS    = 12,
    parameter int N_CH           = 4,
    parameter int NUM_SATS       = 32,
    parameter int CODE_NCO_BITS  = 9,
    parameter int CODE_NCO_OMEGA = 131,
    parameter int DOPP_BITS      = 16,
    parameter int N_DOPP         = 8,
    parameter int DOPP_START     = -400,
    parameter int DOPP_STEP      = 100,
`ifdef GPS_ACK_IQ_EN
    localparam int AW            = SAMPLE_BITS + 3,
`else
    localparam int AW            = SAMPLE_BITS + 2,
`endif
    localparam int DBW           = (N_DOPP > 1) ? $clog2(N_DOPP) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ack_start,
    input  logic           adc_clk,
    input  logic           i_sample,
    input  logic           q_sample,
    output logic           busy,
    output logic           done,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [4:0]     res_sat,
    output logic [AW-1:0]  res_peak,
    output logic [9:0]     res_code_phase,
    output logic [DBW-1:0] res_dopp_bin
);

    localparam int N        = 1 << SAMPLE_BITS;
    localparam int N_GROUPS = (NUM_SATS + N_CH - 1) / N_CH;
    localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CAPTURE    = 3'd1;
    localparam logic [2:0] S_DWELL_INIT = 3'd2;
    localparam logic [2:0] S_CORR       = 3'd3;
    localparam logic [2:0] S_DWELL_END  = 3'd4;
    localparam logic [2:0] S_REPORT     = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    logic [2:0]               state;
    logic [2:0]               adc_sync;
    logic                     strobe;
    logic [N-1:0]             i_buf;
    logic [SAMPLE_BITS-1:0]   samp_cnt;
    logic [5:0]               group;
    logic [9:0]               code_phase;
    logic [DBW-1:0]           dopp_bin;
    logic [10:1]              ps_g1, ps_g2, g1, g2;
    logic [CODE_NCO_BITS-1:0] code_acc;
    logic [CODE_NCO_BITS:0]   code_sum;
    logic [DOPP_BITS-1:0]     carr_phase, carr_omega;
    logic signed [AW-1:0]     acc_i [N_CH];
    logic signed [AW-1:0]     acc_q [N_CH];
    logic signed [AW-1:0]     di [N_CH];
    logic signed [AW-1:0]     dq [N_CH];
    logic [AW-1:0]            mag [N_CH];
    logic [AW-1:0]            peak [N_CH];
    logic [9:0]               peak_phase [N_CH];
    logic [DBW-1:0]           peak_bin [N_CH];
    logic [N_CH-1:0]          chip;
    logic [CW-1:0]            rep_ch;
    logic                     ch_ok;
    logic [1:0]               quad;
    logic                     lo_i, lo_q, smp_i;
    logic [7:0]               tp;
`ifdef GPS_ACK_IQ_EN
    logic [N-1:0]             q_buf;
    logic                     smp_q;
`else
    logic                     unused_q;
    assign unused_q = q_sample;
`endif

    // G2 output tap pair per PRN, packed {tap1, tap2}
    function automatic logic [7:0] g2_taps(input int prn);
        case (prn)
            1:  return {4'd2, 4'd6};   2:  return {4'd3, 4'd7};
            3:  return {4'd4, 4'd8};   4:  return {4'd5, 4'd9};
            5:  return {4'd1, 4'd9};   6:  return {4'd2, 4'd10};
            7:  return {4'd1, 4'd8};   8:  return {4'd2, 4'd9};
            9:  return {4'd3, 4'd10};  10: return {4'd2, 4'd3};
            11: return {4'd3, 4'd4};   12: return {4'd5, 4'd6};
            13: return {4'd6, 4'd7};   14: return {4'd7, 4'd8};
            15: return {4'd8, 4'd9};   16: return {4'd9, 4'd10};
            17: return {4'd1, 4'd4};   18: return {4'd2, 4'd5};
            19: return {4'd3, 4'd6};   20: return {4'd4, 4'd7};
            21: return {4'd5, 4'd8};   22: return {4'd6, 4'd9};
            23: return {4'd1, 4'd3};   24: return {4'd4, 4'd6};
            25: return {4'd5, 4'd7};   26: return {4'd6, 4'd8};
            27: return {4'd7, 4'd9};   28: return {4'd8, 4'd10};
            29: return {4'd1, 4'd6};   30: return {4'd2, 4'd7};
            31: return {4'd3, 4'd8};   32: return {4'd4, 4'd9};
            default: return {4'd1, 4'd2};
        endcase
    endfunction

    function automatic logic [10:1] g1_step(input logic [10:1] g);
        return {g[9:1], g[3] ^ g[10]};
    endfunction

    function automatic logic [10:1] g2_step(input logic [10:1] g);
        return {g[9:1], g[2] ^ g[3] ^ g[6] ^ g[8] ^ g[9] ^ g[10]};
    endfunction

    // Sample bit to +1/-1: a set bit means -1
    function automatic logic signed [AW-1:0] pm1(input logic b);
        logic signed [AW-1:0] r;
        r = b ? '1 : AW'(1);
        return r;
    endfunction

    function automatic logic [AW-1:0] abs_val(input logic signed [AW-1:0] a);
        return a[AW-1] ? AW'(-a) : a;
    endfunction

    assign strobe   = adc_sync[1] & ~adc_sync[2];
    assign code_sum = {1'b0, code_acc} + (CODE_NCO_BITS+1)'(CODE_NCO_OMEGA);
    assign ch_ok    = (int'(group) * N_CH + int'(rep_ch) + 1) <= NUM_SATS;

    // Per-channel chip, carrier wipe-off and magnitude for the current sample
    always_comb begin
        quad  = carr_phase[DOPP_BITS-1 -: 2];
        lo_i  = quad[1] ^ quad[0];
        lo_q  = quad[1];
        smp_i = i_buf[samp_cnt];
        tp    = 8'd0;
        chip  = '0;
`ifdef GPS_ACK_IQ_EN
        smp_q = q_buf[samp_cnt];
`endif
        for (int c = 0; c < N_CH; c++) begin
            tp      = g2_taps(int'(group) * N_CH + c + 1);
            chip[c] = g1[10] ^ g2[tp[7:4]] ^ g2[tp[3:0]];
`ifdef GPS_ACK_IQ_EN
            di[c] = pm1(smp_i ^ chip[c] ^ lo_i) + pm1(smp_q ^ chip[c] ^ lo_q);
            dq[c] = pm1(smp_q ^ chip[c] ^ lo_i) - pm1(smp_i ^ chip[c] ^ lo_q);
`else
            di[c] = pm1(smp_i ^ chip[c] ^ lo_i);
            dq[c] = pm1(smp_i ^ chip[c] ^ lo_q);
`endif
            mag[c] = abs_val(acc_i[c]) + abs_val(acc_q[c]);
        end
    end

    // Sample buffer has no reset; contents only matter after a full capture
    always_ff @(posedge clk) begin
        if (rst && state == S_CAPTURE && strobe) begin
            i_buf[samp_cnt] <= i_sample;
`ifdef GPS_ACK_IQ_EN
            q_buf[samp_cnt] <= q_sample;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            adc_sync   <= '0;
            samp_cnt   <= '0;
            group      <= '0;
            code_phase <= '0;
            dopp_bin   <= '0;
            ps_g1      <= '0;
            ps_g2      <= '0;
            g1         <= '0;
            g2         <= '0;
            code_acc   <= '0;
            carr_phase <= '0;
            carr_omega <= '0;
            rep_ch     <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc_i[c]      <= '0;
                acc_q[c]      <= '0;
                peak[c]       <= '0;
                peak_phase[c] <= '0;
                peak_bin[c]   <= '0;
            end
        end else begin
            adc_sync <= {adc_sync[1:0], adc_clk};
            case (state)
                S_IDLE: begin
                    if (ack_start) begin
                        state      <= S_CAPTURE;
                        samp_cnt   <= '0;
                        group      <= '0;
                        code_phase <= '0;
                        dopp_bin   <= '0;
                        ps_g1      <= '1;
                        ps_g2      <= '1;
                        rep_ch     <= '0;
                        for (int c = 0; c < N_CH; c++) begin
                            peak[c]       <= '0;
                            peak_phase[c] <= '0;
                            peak_bin[c]   <= '0;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (strobe) begin
                        samp_cnt <= samp_cnt + SAMPLE_BITS'(1);
                        if (samp_cnt == '1)
                            state <= S_DWELL_INIT;
                    end
                end
                S_DWELL_INIT: begin
                    for (int c = 0; c < N_CH; c++) begin
                        acc_i[c] <= '0;
                        acc_q[c] <= '0;
                    end
                    code_acc   <= '0;
                    carr_phase <= '0;
                    g1         <= ps_g1;
                    g2         <= ps_g2;
                    carr_omega <= DOPP_BITS'(DOPP_START + DOPP_STEP * int'(dopp_bin));
                    samp_cnt   <= '0;
                    state      <= S_CORR;
                end
                S_CORR: begin
                    for (int c = 0; c < N_CH; c++) begin
                        acc_i[c] <= acc_i[c] + di[c];
                        acc_q[c] <= acc_q[c] + dq[c];
                    end
                    code_acc <= code_sum[CODE_NCO_BITS-1:0];
                    if (code_sum[CODE_NCO_BITS]) begin
                        g1 <= g1_step(g1);
                        g2 <= g2_step(g2);
                    end
                    carr_phase <= carr_phase + carr_omega;
                    samp_cnt   <= samp_cnt + SAMPLE_BITS'(1);
                    if (samp_cnt == '1)
                        state <= S_DWELL_END;
                end
                S_DWELL_END: begin
                    // Strictly greater so that ties keep the earliest phase/bin
                    for (int c = 0; c < N_CH; c++) begin
                        if (mag[c] > peak[c]) begin
                            peak[c]       <= mag[c];
                            peak_phase[c] <= code_phase;
                            peak_bin[c]   <= dopp_bin;
                        end
                    end
                    if (int'(dopp_bin) < N_DOPP - 1) begin
                        dopp_bin <= dopp_bin + DBW'(1);
                        state    <= S_DWELL_INIT;
                    end else begin
                        dopp_bin <= '0;
                        if (code_phase < 10'd1022) begin
                            code_phase <= code_phase + 10'd1;
                            ps_g1      <= g1_step(ps_g1);
                            ps_g2      <= g2_step(ps_g2);
                            state      <= S_DWELL_INIT;
                        end else begin
                            rep_ch <= '0;
                            state  <= S_REPORT;
                        end
                    end
                end
                S_REPORT: begin
                    if (!ch_ok || res_ready) begin
                        if (int'(rep_ch) == N_CH - 1) begin
                            rep_ch <= '0;
                            if (int'(group) == N_GROUPS - 1) begin
                                state <= S_DONE;
                            end else begin
                                group      <= group + 6'd1;
                                code_phase <= '0;
                                dopp_bin   <= '0;
                                ps_g1      <= '1;
                                ps_g2      <= '1;
                                for (int c = 0; c < N_CH; c++) begin
                                    peak[c]       <= '0;
                                    peak_phase[c] <= '0;
                                    peak_bin[c]   <= '0;
                                end
                                state <= S_DWELL_INIT;
                            end
                        end else begin
                            rep_ch <= rep_ch + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign res_valid      = (state == S_REPORT) && ch_ok;
    assign res_sat        = res_valid ? 5'(int'(group) * N_CH + int'(rep_ch)) : 5'd0;
    assign res_peak       = res_valid ? peak[rep_ch] : '0;
    assign res_code_phase = res_valid ? peak_phase[rep_ch] : 10'd0;
    assign res_dopp_bin   = res_valid ? peak_bin[rep_ch] : '0;

endmodule

// File: tb/tb_gps_ack_multi.sv
// tb_gps_ack_multi: random-sample acquisition runs on a small gps_ack_multi,
// compared with a reference correlator that searches the C/A code by chip index.
module tb_gps_ack_multi;

    localparam int SAMPLE_BITS = 3;
    localparam int N           = 1 << SAMPLE_BITS;
    localparam int N_CH        = 2;
    localparam int NUM_SATS    = 3;
    localparam int N_GROUPS    = (NUM_SATS + N_CH - 1) / N_CH;
    localparam int NCO_BITS    = 9;
    localparam int NCO_OMEGA   = 131;
    localparam int DOPP_BITS   = 16;
    localparam int N_DOPP      = 2;
    localparam int DOPP_START  = -8192;
    localparam int DOPP_STEP   = 16384;
    localparam int DBW         = 1;
`ifdef GPS_ACK_IQ_EN
    localparam int PW          = SAMPLE_BITS + 3;
`else
    localparam int PW          = SAMPLE_BITS + 2;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           ack_start;
    logic           adc_clk;
    logic           i_sample;
    logic           q_sample;
    logic           busy;
    logic           done;
    logic           res_valid;
    logic           res_ready;
    logic [4:0]     res_sat;
    logic [PW-1:0]  res_peak;
    logic [9:0]     res_code_phase;
    logic [DBW-1:0] res_dopp_bin;

    int n_vec = 0;
    int n_err = 0;

    bit smp_i [N];
    bit smp_q [N];
    bit ca [1023];
    int exp_sat[$];
    int exp_peak[$];
    int exp_phase[$];
    int exp_bin[$];

    int tap1 [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tap2 [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    gps_ack_multi #(
        .SAMPLE_BITS(SAMPLE_BITS), .N_CH(N_CH), .NUM_SATS(NUM_SATS),
        .CODE_NCO_BITS(NCO_BITS), .CODE_NCO_OMEGA(NCO_OMEGA), .DOPP_BITS(DOPP_BITS),
        .N_DOPP(N_DOPP), .DOPP_START(DOPP_START), .DOPP_STEP(DOPP_STEP)
    ) dut (
        .clk(clk), .rst(rst), .ack_start(ack_start), .adc_clk(adc_clk),
        .i_sample(i_sample), .q_sample(q_sample), .busy(busy), .done(done),
        .res_valid(res_valid), .res_ready(res_ready), .res_sat(res_sat),
        .res_peak(res_peak), .res_code_phase(res_code_phase), .res_dopp_bin(res_dopp_bin)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full C/A period for a PRN, chip n = code at phase offset n
    task automatic fill_code(input int prn);
        bit [10:1] a;
        bit [10:1] b;
        a = '1;
        b = '1;
        for (int n = 0; n < 1023; n++) begin
            ca[n] = a[10] ^ b[tap1[prn-1]] ^ b[tap2[prn-1]];
            a = {a[9:1], a[3] ^ a[10]};
            b = {b[9:1], b[2] ^ b[3] ^ b[6] ^ b[8] ^ b[9] ^ b[10]};
        end
    endtask

    function automatic int pm(input bit b);
        return b ? -1 : 1;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Exhaustive search in chip-index/carrier-angle terms, best = first strict maximum
    task automatic compute_model();
        int prn, best, bp, bb, om, si, sq, quad, mg;
        bit chip, li, lq;
        exp_sat.delete(); exp_peak.delete(); exp_phase.delete(); exp_bin.delete();
        for (int g = 0; g < N_GROUPS; g++) begin
            for (int c = 0; c < N_CH; c++) begin
                prn = g * N_CH + c + 1;
                if (prn <= NUM_SATS) begin
                    fill_code(prn);
                    best = 0; bp = 0; bb = 0;
                    for (int p = 0; p < 1023; p++) begin
                        for (int bin = 0; bin < N_DOPP; bin++) begin
                            om = (DOPP_START + bin * DOPP_STEP) & 32'hFFFF;
                            si = 0; sq = 0;
                            for (int k = 0; k < N; k++) begin
                                chip = ca[(p + (k * NCO_OMEGA) / (1 << NCO_BITS)) % 1023];
                                quad = ((k * om) % 65536) / 16384;
                                li   = (quad == 1) || (quad == 2);
                                lq   = (quad >= 2);
`ifdef GPS_ACK_IQ_EN
                                si += pm(smp_i[k] ^ chip ^ li) + pm(smp_q[k] ^ chip ^ lq);
                                sq += pm(smp_q[k] ^ chip ^ li) - pm(smp_i[k] ^ chip ^ lq);
`else
                                si += pm(smp_i[k] ^ chip ^ li);
                                sq += pm(smp_i[k] ^ chip ^ lq);
`endif
                            end
                            mg = iabs(si) + iabs(sq);
                            if (mg > best) begin
                                best = mg; bp = p; bb = bin;
                            end
                        end
                    end
                    exp_sat.push_back(prn - 1);
                    exp_peak.push_back(best);
                    exp_phase.push_back(bp);
                    exp_bin.push_back(bb);
                end
            end
        end
    endtask

    task automatic apply_stimulus(input bit iv, input bit qv);
        i_sample = iv;
        q_sample = qv;
        @(negedge clk);
        adc_clk = 1'b1;
        repeat (4) @(negedge clk);
        adc_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int idx, cyc;
        bit done_seen, hold_done, saw_done;
        logic [31:0] exp_pack;

        rst = 1'b0; ack_start = 1'b0; adc_clk = 1'b0;
        i_sample = 1'b0; q_sample = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_done", 32'(done), 0);
        check_output("rst_valid", 32'(res_valid), 0);
        check_output("rst_sat", 32'(res_sat), 0);
        check_output("rst_peak", 32'(res_peak), 0);
        check_output("rst_phase", 32'(res_code_phase), 0);
        check_output("rst_bin", 32'(res_dopp_bin), 0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("idle_busy", 32'(busy), 0);

        // First search, aborted by a one-cycle reset in the middle of the dwell loop
        ack_start = 1'b1;
        @(negedge clk);
        ack_start = 1'b0;
        check_output("start_busy", 32'(busy), 1);
        for (int k = 0; k < N; k++)
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (233) @(negedge clk);
        check_output("pre_abort_busy", 32'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_output("abort_busy", 32'(busy), 0);
        check_output("abort_valid", 32'(res_valid), 0);
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check_output("abort_no_done", 32'(saw_done), 0);
        check_output("abort_idle", 32'(busy), 0);

        // Second search: PRN 2 injected at phase 37 with occasional bit errors
        fill_code(2);
        for (int k = 0; k < N; k++) begin
            smp_i[k] = ca[(37 + (k * NCO_OMEGA) / (1 << NCO_BITS)) % 1023] ^ ($urandom_range(0, 7) == 0);
            smp_q[k] = 1'($urandom_range(0, 1));
        end
        compute_model();
        $display("[TB] model: %0d results expected", exp_sat.size());

        ack_start = 1'b1;
        @(negedge clk);
        ack_start = 1'b0;
        for (int k = 0; k < N; k++)
            apply_stimulus(smp_i[k], smp_q[k]);

        idx = 0; cyc = 0; done_seen = 1'b0; hold_done = 1'b0;
        while (!done_seen && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                done_seen = 1'b1;
                check_output("done_after_all", 32'(idx), NUM_SATS);
            end else if (res_valid) begin
                if (idx >= exp_sat.size()) begin
                    check_output("extra_result", 32'(idx), exp_sat.size() - 1);
                    res_ready = 1'b1;
                end else begin
                    exp_pack = {1'b1, 5'(exp_sat[idx]), 10'(exp_phase[idx]),
                                DBW'(exp_bin[idx]), PW'(exp_peak[idx])};
                    if (!hold_done) begin
                        res_ready = 1'b0;
                        for (int h = 0; h < 50; h++) begin
                            check_output("hold_stable",
                                32'({res_valid, res_sat, res_code_phase, res_dopp_bin, res_peak}), exp_pack);
                            @(negedge clk);
                        end
                        hold_done = 1'b1;
                    end
                    res_ready = 1'($urandom_range(0, 1));
                    if (res_ready) begin
                        check_output("res_sat", 32'(res_sat), exp_sat[idx]);
                        check_output("res_peak", 32'(res_peak), exp_peak[idx]);
                        check_output("res_phase", 32'(res_code_phase), exp_phase[idx]);
                        check_output("res_bin", 32'(res_dopp_bin), exp_bin[idx]);
                        idx++;
                    end
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
        end
        check_output("done_seen", 32'(done_seen), 1);
        check_output("result_count", 32'(idx), NUM_SATS);
        res_ready = 1'b0;
        @(negedge clk);
        check_output("post_done_busy", 32'(busy), 0);
        check_output("post_done_pulse", 32'(done), 0);
        check_output("post_done_valid", 32'(res_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
